// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: one N-bit, MSB-first, SPI mode-0 full-duplex transfer per accepted start.
// Define SPI_INIT_CLOCKS_EN to add the SD power-up dummy-clock sequence after reset release.
module spi_master_ctrl #(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] data_in,
  input  logic         hold_cs,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] data_out,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso,
  output logic         cs_n
);

  localparam int CW = $clog2(DIV + 1);
  localparam int BW = $clog2(N + 1);

`ifdef SPI_INIT_CLOCKS_EN
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SETUP, S_HIGH, S_LOW, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-1:0]  tx_q, tx_d;
  logic [N-1:0]  rx_q, rx_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          hold_q, hold_d;
  logic          csn_q, csn_d;
  logic          tick;
`ifdef SPI_INIT_CLOCKS_EN
  logic [7:0]    half_q, half_d;
  logic          init_done_q, init_done_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '1;
      rx_q        <= '0;
      dout_q      <= '0;
      hold_q      <= 1'b0;
      csn_q       <= 1'b1;
`ifdef SPI_INIT_CLOCKS_EN
      half_q      <= '0;
      init_done_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      dout_q      <= dout_d;
      hold_q      <= hold_d;
      csn_q       <= csn_d;
`ifdef SPI_INIT_CLOCKS_EN
      half_q      <= half_d;
      init_done_q <= init_done_d;
`endif
    end
  end

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    hold_d  = hold_q;
    csn_d   = csn_q;
`ifdef SPI_INIT_CLOCKS_EN
    half_d      = half_q;
    init_done_d = init_done_q;
`endif
    unique case (state_q)
`ifdef SPI_INIT_CLOCKS_EN
      // 160 half-periods of DIV cycles; odd half-periods drive sclk high
      S_INIT: begin
        if (tick) begin
          cnt_d = '0;
          if (half_q == 8'd159) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end else begin
            half_d = half_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_IDLE: begin
`ifdef SPI_INIT_CLOCKS_EN
        if (!init_done_q) begin
          state_d = S_INIT;
          cnt_d   = '0;
          half_d  = '0;
        end else
`endif
        if (start) begin
          tx_d    = data_in;
          hold_d  = hold_cs;
          csn_d   = 1'b0;
          bit_d   = '0;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP, S_LOW: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = S_HIGH;
          rx_d    = {rx_q[N-2:0], miso};
          bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (tick) begin
          cnt_d = '0;
          if (bit_q < BW'(N)) begin
            state_d = S_LOW;
            tx_d    = {tx_q[N-2:0], 1'b1};
          end else begin
            state_d = S_DONE;
            dout_d  = rx_q;
            csn_d   = ~hold_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign data_out = dout_q;
  assign cs_n     = csn_q;
  assign mosi     = (state_q == S_SETUP || state_q == S_HIGH || state_q == S_LOW) ? tx_q[N-1] : 1'b1;
`ifdef SPI_INIT_CLOCKS_EN
  assign sclk     = (state_q == S_HIGH) || (state_q == S_INIT && half_q[0]);
`else
  assign sclk     = (state_q == S_HIGH);
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl (N=8, DIV=4): scoreboard of expected received bytes,
// sclk-rise timing, chip-select hold, busy rejection and reset abort.
module tb_spi_master_ctrl;
  localparam int N   = 8;
  localparam int DIV = 4;
  localparam int LAT = 2 * N * DIV;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] data_in = '0;
  logic         hold_cs = 1'b0;
  logic         busy, done, sclk, mosi, miso, cs_n;
  logic [N-1:0] data_out;

  spi_master_ctrl #(.N(N), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .hold_cs(hold_cs),
    .busy(busy), .done(done), .data_out(data_out), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records sclk rise cycles, counts falls and done pulses.
  int   rise_q[$];
  int   falls = 0;
  int   n_done = 0;
  logic sclk_prev = 1'b0;
  always @(negedge clk) begin
    if (sclk && !sclk_prev) rise_q.push_back(cyc);
    if (!sclk && sclk_prev) falls++;
    if (done) n_done++;
    sclk_prev = sclk;
  end

  logic         loop_en = 1'b1;
  logic [N-1:0] rx_pat = '0;
  int           falls_base = 0;
  always_comb begin
    int fi;
    fi = falls - falls_base;
    if (loop_en)                miso = mosi;
    else if (fi >= 0 && fi < N) miso = rx_pat[N-1-fi];
    else                        miso = 1'b1;
  end

  int           n_tests = 0;
  int           n_fail = 0;
  int           t0 = 0;
  int           rises_base = 0;
  int           exp_dones = 0;
  logic         cs_hi_seen;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) step();
  endtask

  task automatic start_xfer(input logic [N-1:0] d, input logic h);
    int guard = 0;
    while (busy && guard < 500) begin step(); guard++; end
    check("idle_before_start", busy, 1'b0);
    start = 1'b1; data_in = d; hold_cs = h;
    falls_base = falls;
    step();
    t0 = cyc;
    rises_base = rise_q.size();
    start = 1'b0;
    check("busy_accept", busy, 1'b1);
    check("cs_n_accept", cs_n, 1'b0);
    check("mosi_msb", mosi, d[N-1]);
  endtask

  task automatic wait_done(input logic exp_csn, input bit post);
    int guard = 0;
    while (!done && guard < 400) begin
      if (cs_n) cs_hi_seen = 1'b1;
      step();
      guard++;
    end
    if (!done) begin
      check("done_timeout", 1'b0, 1'b1);
      return;
    end
    check("done_lat", cyc - t0, LAT);
    if (exp_q.size() == 0) check("spurious_done", 1'b1, 1'b0);
    else check("data_out", data_out, exp_q.pop_front());
    check("cs_n_done", cs_n, exp_csn);
    check("mosi_done", mosi, 1'b1);
    check("sclk_done", sclk, 1'b0);
    check("busy_done", busy, 1'b1);
    check("rise_count", rise_q.size() - rises_base, N);
    if (rise_q.size() - rises_base == N)
      for (int k = 0; k < N; k++)
        check("sclk_rise", rise_q[rises_base + k] - t0, DIV + 2 * DIV * k);
    if (post) begin
      step();
      check("busy_after", busy, 1'b0);
      check("done_after", done, 1'b0);
    end
  endtask

  initial begin
    int d1, rel, base, guard;
    logic init_bad;
    repeat (3) step();
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b1);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data_out", data_out, '0);

`ifdef SPI_INIT_CLOCKS_EN
    reset = 1'b0;
    rel = cyc + 1;
    base = rise_q.size();
    init_bad = 1'b0;
    start = 1'b1; data_in = 8'h77;
    step();
    check("init_busy", busy, 1'b1);
    guard = 0;
    while (busy && guard < 200 * DIV) begin
      if (cs_n !== 1'b1 || mosi !== 1'b1) init_bad = 1'b1;
      if (cyc - rel > 100) start = 1'b0;
      step();
      guard++;
    end
    check("init_len", cyc - rel, 160 * DIV);
    check("init_rises", rise_q.size() - base, 80);
    check("init_pins", init_bad, 1'b0);
    check("init_no_done", n_done, 0);
`else
    reset = 1'b0;
    step();
    check("idle_busy", busy, 1'b0);
`endif

    // Loopback 0xA5
    loop_en = 1'b1;
    exp_q.push_back(8'hA5); exp_dones++;
    start_xfer(8'hA5, 1'b0);
    wait_done(1'b1, 1);

    // Receive pattern 0x3C on miso, 0xC3 transmitted
    loop_en = 1'b0;
    rx_pat = 8'h3C;
    exp_q.push_back(8'h3C); exp_dones++;
    start_xfer(8'hC3, 1'b0);
    wait_done(1'b1, 1);
    loop_en = 1'b1;

    // Chip-select hold: 0x40 with hold, then 0xFF with start held high
    exp_q.push_back(8'h40); exp_q.push_back(8'hFF); exp_dones += 2;
    start_xfer(8'h40, 1'b1);
    start = 1'b1; data_in = 8'hFF; hold_cs = 1'b0;
    cs_hi_seen = 1'b0;
    wait_done(1'b0, 0);
    d1 = cyc;
    step();
    check("gap_busy", busy, 1'b0);
    check("gap_cs_n", cs_n, 1'b0);
    step();
    check("second_accept", busy, 1'b1);
    check("second_accept_cyc", cyc - d1, 2);
    t0 = cyc;
    rises_base = rise_q.size();
    start = 1'b0;
    wait_done(1'b1, 1);
    check("cs_n_held_low", cs_hi_seen, 1'b0);

    // Busy rejection
    exp_q.push_back(8'h96); exp_dones++;
    start_xfer(8'h96, 1'b0);
    wait_cyc(t0 + 10);
    start = 1'b1; data_in = 8'h11;
    step();
    start = 1'b0;
    wait_done(1'b1, 0);
    start = 1'b1; data_in = 8'h22;
    step();
    start = 1'b0;
    check("rej_busy", busy, 1'b0);
    check("rej_done", done, 1'b0);
    repeat (150) step();
    check("rej_one_done", n_done, exp_dones);
    check("rej_data_held", data_out, 8'h96);

    // Reset abort mid-transfer
    start_xfer(8'h5A, 1'b0);
    wait_cyc(t0 + 30);
    reset = 1'b1;
    step();
    check("abort_sclk", sclk, 1'b0);
    check("abort_mosi", mosi, 1'b1);
    check("abort_cs_n", cs_n, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_data_out", data_out, '0);
    reset = 1'b0;
`ifdef SPI_INIT_CLOCKS_EN
    guard = 0;
    step();
    while (busy && guard < 200 * DIV) begin step(); guard++; end
`endif
    repeat (20) step();
    check("abort_no_done", n_done, exp_dones);

    // Normal transfer after abort
    exp_q.push_back(8'h3B); exp_dones++;
    start_xfer(8'h3B, 1'b0);
    wait_done(1'b1, 1);

    repeat (5) step();
    check("total_dones", n_done, exp_dones);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
